button_event_capture: RTL
=========================

# button_event_capture

Front-end input stage feeding the CPU platform's inputs PIO.

- Per button:
  - two-flop synchroniser
  - counter-based debounce
  - one-cycle press pulse
  - optional hold-to-repeat pulses
  - sticky event flag the CPU clears with write-1-to-clear
- Lets firmware see every press exactly once instead of polling debounced levels.
- Drops in ahead of the PIO, in place of the per-button debouncer instances.

## Interface

Parameters:
- N_BUTTONS, 4: number of independent button channels.
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable synchronised samples required to accept a level change (20 ms at 50 MHz).
- HOLD_CYCLES, 25_000_000: press duration before the first repeat pulse.
- REPEAT_CYCLES, 5_000_000: interval between subsequent repeat pulses.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- buttons_n  in  N_BUTTONS  raw pad inputs, active-low (0 = pressed)
- repeat_en  in  1  enables hold-to-repeat pulses on all channels
- events_clr  in  N_BUTTONS  write-1-to-clear strobes for events, one cycle
- pressed  out  N_BUTTONS  debounced level, 1 = pressed
- press_pulse  out  N_BUTTONS  one-cycle pulse per accepted press or repeat
- events  out  N_BUTTONS  sticky flag, set by press_pulse, cleared by events_clr

## Operation

Per-channel state machine:
- RELEASED: the counter runs while the synchronised input is pressed; it resets to 0 on any released sample. Reaching DEBOUNCE_CYCLES goes to PRESSED and fires press_pulse.
- PRESSED: the hold counter increments each cycle. Reaching HOLD_CYCLES with repeat_en=1 fires press_pulse, goes to REPEAT and resets the counter. With repeat_en=0 the counter saturates and no pulse fires.
- REPEAT: a pulse fires every REPEAT_CYCLES while repeat_en=1. If repeat_en drops, pulses stop; the state is kept and the counter keeps running.
- Release detection: from PRESSED or REPEAT, a debounce counter runs on released samples and resets on any pressed sample. Reaching DEBOUNCE_CYCLES goes to RELEASED and clears pressed. Release produces no pulse.
- Bouncing: any sample that disagrees with the candidate level restarts that debounce count at 0.

events register:
- Bit is set on the clock edge where press_pulse is 1.
- Bit is cleared on the edge where events_clr is 1.
- Simultaneous set and clear: set wins, so the bit stays 1.

Widths and isolation:
- Counter widths are $clog2 of the largest of the three cycle parameters plus 1.
- Counters never wrap.
- Channels are fully independent; simultaneous presses on several channels each pulse in their own cycle.

## Timing

- Reset values, asynchronous:
  - synchroniser flops 1 (released)
  - all counters 0, state RELEASED
  - pressed 0, press_pulse 0, events 0
- Press latency: raw falling edge at cycle 0 held low → pressed and press_pulse high at cycle 2+DEBOUNCE_CYCLES.
- press_pulse is high for exactly one cycle.
- events bit is visible one cycle after press_pulse.
- First repeat pulse comes HOLD_CYCLES cycles after the press pulse; each later one REPEAT_CYCLES after the previous.
- Release latency: raw rising edge → pressed low at cycle 2+DEBOUNCE_CYCLES.
- reset_n asserted mid-press: all outputs go to reset values immediately. After deassertion, a button still held is re-debounced and produces a fresh pulse.
- Outputs are registered; press_pulse, pressed and events have no combinational path from inputs.

## Structure

- Shared package button_pkg:
  - channel state enum btn_state_t {RELEASED, PRESSED, REPEAT}
  - counter-width helper function
  - default cycle constants
- Sub-module button_channel:
  - one instance per bit via generate
  - contains synchroniser, debounce/hold counters, FSM, pulse and events bit
- Top level: instance array plus parameter pass-through only.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, N_BUTTONS=4.

- Clean press: buttons_n[0] low at cycle 0 and held → press_pulse[0] high only at cycle 6, pressed[0]=1 from 6, events[0]=1 from 7; other bits stay 0.
- Bounce: buttons_n[1] toggles low/high/low at cycles 0,2,3, then held low → pulse at cycle 9; exactly one pulse.
- Repeat: repeat_en=1, buttons_n[2] held → pulses at cycles 6, 16, 19, 22. Drop repeat_en at cycle 20 → no pulse at 22. Release → pressed[2] low 6 cycles after the rising edge.
- Sticky clear: events[3]=1, then events_clr[3] one cycle → events[3]=0 next cycle. Clear coinciding with press_pulse[3] → events[3] stays 1.
- Reset mid-press: reset_n low during PRESSED with button held → all outputs 0 asynchronously. After release of reset_n at cycle R → new pulse at R+6.
- Simultaneous: all four buttons fall at cycle 0 → press_pulse=4'b1111 at cycle 6, events=4'b1111 at 7.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the button event capture front-end.
package button_pkg;

  typedef enum logic [1:0] {RELEASED, PRESSED, REPEAT} btn_state_t;

  localparam int DEF_N_BUTTONS       = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;
  localparam int DEF_HOLD_CYCLES     = 25_000_000;
  localparam int DEF_REPEAT_CYCLES   = 5_000_000;

  // One counter width serves debounce, hold and repeat so every counter reaches its terminal value.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button: synchroniser, debounce/hold counters, state machine, press pulse and sticky event bit.
module button_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_n_i,
  input  logic repeat_en_i,
  input  logic event_clr_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic event_o
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic          sync1_q, sync2_q;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] db_q, db_d, hold_q, hold_d;
  logic          pulse_q, pulse_d, pressed_q, pressed_d, ev_q, ev_d;
  logic          smp_pressed;

  assign smp_pressed = ~sync2_q;

  always_comb begin
    state_d = state_q;
    db_d    = db_q;
    hold_d  = hold_q;
    pulse_d = 1'b0;
    case (state_q)
      RELEASED: begin
        hold_d = '0;
        if (!smp_pressed) db_d = '0;
        else if (db_q == DB_LAST) begin
          db_d    = '0;
          state_d = PRESSED;
          pulse_d = 1'b1;
        end else db_d = db_q + 1'b1;
      end
      default: begin
        if (state_q == PRESSED) begin
          // Without repeat_en the hold count parks at its last value.
          if (hold_q == HOLD_LAST) begin
            if (repeat_en_i) begin
              pulse_d = 1'b1;
              state_d = REPEAT;
              hold_d  = '0;
            end
          end else hold_d = hold_q + 1'b1;
        end else begin
          if (hold_q == REP_LAST) begin
            hold_d  = '0;
            pulse_d = repeat_en_i;
          end else hold_d = hold_q + 1'b1;
        end
        // Accepted release wins over a coincident repeat pulse.
        if (smp_pressed) db_d = '0;
        else if (db_q == DB_LAST) begin
          db_d    = '0;
          hold_d  = '0;
          state_d = RELEASED;
          pulse_d = 1'b0;
        end else db_d = db_q + 1'b1;
      end
    endcase
    pressed_d = (state_d != RELEASED);
    ev_d      = pulse_q ? 1'b1 : (event_clr_i ? 1'b0 : ev_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= RELEASED;
      db_q      <= '0;
      hold_q    <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
      ev_q      <= 1'b0;
    end else begin
      sync1_q   <= button_n_i;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      db_q      <= db_d;
      hold_q    <= hold_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
      ev_q      <= ev_d;
    end
  end

  assign pressed_o     = pressed_q;
  assign press_pulse_o = pulse_q;
  assign event_o       = ev_q;

endmodule

// File: rtl/button_event_capture.sv
// Array of independent button channels in front of the inputs PIO.
module button_event_capture
  import button_pkg::*;
#(
  parameter int N_BUTTONS       = DEF_N_BUTTONS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BUTTONS-1:0] buttons_n,
  input  logic                 repeat_en,
  input  logic [N_BUTTONS-1:0] events_clr,
  output logic [N_BUTTONS-1:0] pressed,
  output logic [N_BUTTONS-1:0] press_pulse,
  output logic [N_BUTTONS-1:0] events
);

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .HOLD_CYCLES    (HOLD_CYCLES),
      .REPEAT_CYCLES  (REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .button_n_i   (buttons_n[i]),
      .repeat_en_i  (repeat_en),
      .event_clr_i  (events_clr[i]),
      .pressed_o    (pressed[i]),
      .press_pulse_o(press_pulse[i]),
      .event_o      (events[i])
    );
  end

endmodule
